// File: rtl/filter_decimator_if.sv
// Bundles the sample-in strobe, the valid/ready output stream and the status flags
// that pass between the FIR output, filter_decimator and the downstream consumer.
interface filter_decimator_if #(
    parameter int DataWidth  = 16,
    parameter int DecimWidth = 8,
    parameter int Depth      = 4
);
    localparam int FillWidth = $clog2(Depth) + 1;

    logic                        clear_i;
    logic [DecimWidth-1:0]       decim_i;
    logic                        data_in_req_i;
    logic signed [DataWidth-1:0] data_in_i;
    logic                        data_out_valid_o;
    logic                        data_out_ready_i;
    logic signed [DataWidth-1:0] data_out_o;
    logic [FillWidth-1:0]        fill_o;
    logic                        overflow_o;

    modport slave (
        input  clear_i, decim_i, data_in_req_i, data_in_i, data_out_ready_i,
        output data_out_valid_o, data_out_o, fill_o, overflow_o
    );

    modport master (
        output clear_i, decim_i, data_in_req_i, data_in_i, data_out_ready_i,
        input  data_out_valid_o, data_out_o, fill_o, overflow_o
    );
endinterface

// File: rtl/filter_decimator.sv
// Keeps every N-th FIR output sample and queues the kept ones in a small
// first-word-fall-through FIFO drained over a valid/ready handshake.
module filter_decimator #(
    parameter int DataWidth  = 16,
    parameter int DecimWidth = 8,
    parameter int Depth      = 4
) (
    input logic                clk_i,
    input logic                rst_ni,
    filter_decimator_if.slave  bus
);
    localparam int AddrWidth = $clog2(Depth);
    localparam int FillWidth = AddrWidth + 1;
    localparam logic [FillWidth-1:0] FullCount = FillWidth'(Depth);

    logic [DecimWidth-1:0]       phase;
    logic [DecimWidth-1:0]       nlat;
    logic [DecimWidth-1:0]       decim_eff;
    logic [AddrWidth-1:0]        wr_ptr;
    logic [AddrWidth-1:0]        rd_ptr;
    logic [FillWidth-1:0]        count;
    logic                        overflow;
    logic signed [DataWidth-1:0] mem [Depth];

    logic strobe, keep, wrap, full, empty, pop, push, drop;

    always_comb begin
        decim_eff = (bus.decim_i == '0) ? DecimWidth'(1) : bus.decim_i;
        // A strobe coinciding with clear is discarded outright.
        strobe    = bus.data_in_req_i & ~bus.clear_i;
        keep      = strobe & (phase == '0);
        wrap      = (phase == nlat - DecimWidth'(1));
        full      = (count == FullCount);
        empty     = (count == '0);
        pop       = ~empty & bus.data_out_ready_i & ~bus.clear_i;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push      = keep & (~full | pop);
        drop      = keep & full & ~pop;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase    <= '0;
            nlat     <= DecimWidth'(1);
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (bus.clear_i) begin
            phase    <= '0;
            nlat     <= decim_eff;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // The factor is only re-sampled at a period boundary.
            if (strobe) begin
                if (wrap) begin
                    phase <= '0;
                    nlat  <= decim_eff;
                end else begin
                    phase <= phase + DecimWidth'(1);
                end
            end
            if (push) wr_ptr <= wr_ptr + AddrWidth'(1);
            if (pop)  rd_ptr <= rd_ptr + AddrWidth'(1);
            case ({push, pop})
                2'b10:   count <= count + FillWidth'(1);
                2'b01:   count <= count - FillWidth'(1);
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= bus.data_in_i;
    end

    assign bus.data_out_valid_o = ~empty;
    assign bus.data_out_o       = empty ? '0 : mem[rd_ptr];
    assign bus.fill_o           = count;
    assign bus.overflow_o       = overflow;
endmodule

// File: tb/tb_filter_decimator.sv
// Directed bench for filter_decimator: decimation, pass-through, backpressure,
// overflow, full push/pop, mid-period factor change, clear and async reset.
module tb_filter_decimator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [15:0] got[$];
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    filter_decimator_if #(.DataWidth(16), .DecimWidth(8), .Depth(4)) bus ();

    filter_decimator #(.DataWidth(16), .DecimWidth(8), .Depth(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are set at the falling edge; a pop seen here is the one the next rising edge performs.
    task automatic step();
        #1;
        if (rst_n && !bus.clear_i && bus.data_out_valid_o && bus.data_out_ready_i)
            got.push_back(bus.data_out_o);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_q(input string tag);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk(tag, (i < got.size()) ? {16'h0, got[i]} : 32'hDEAD_BEEF, {16'h0, exp_q[i]});
        got.delete();
        exp_q.delete();
    endtask

    task automatic do_clear(input logic [7:0] d);
        bus.decim_i = d;
        bus.clear_i = 1'b1;
        step();
        bus.clear_i = 1'b0;
    endtask

    initial begin
        bus.clear_i          = 1'b0;
        bus.decim_i          = 8'd1;
        bus.data_in_req_i    = 1'b0;
        bus.data_in_i        = '0;
        bus.data_out_ready_i = 1'b0;

        // Reset held while strobing
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.data_in_req_i = ~bus.data_in_req_i;
            bus.data_in_i     = 16'(i + 1);
            step();
        end
        chk("rst_valid", bus.data_out_valid_o, 1'b0);
        chk("rst_fill", bus.fill_o, 3'd0);
        chk("rst_ovf", bus.overflow_o, 1'b0);
        chk("rst_data", bus.data_out_o, 16'h0);
        bus.data_in_req_i = 1'b0;
        rst_n = 1'b1;
        step();
        step();
        chk("idle_valid", bus.data_out_valid_o, 1'b0);
        chk("idle_fill", bus.fill_o, 3'd0);

        // Decimate by 3
        do_clear(8'd3);
        bus.data_out_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.data_in_req_i = 1'b1;
            bus.data_in_i     = 16'(i);
            step();
            if (i % 3 == 0) begin
                chk("d3_valid", bus.data_out_valid_o, 1'b1);
                chk("d3_data", bus.data_out_o, 16'(i));
            end else begin
                chk("d3_gap", bus.data_out_valid_o, 1'b0);
            end
        end
        bus.data_in_req_i = 1'b0;
        step();
        step();
        for (int i = 0; i < 12; i += 3) exp_q.push_back(16'(i));
        chk_q("d3_out");
        chk("d3_ovf", bus.overflow_o, 1'b0);

        // Zero factor then factor 1: pass-through
        do_clear(8'd0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) bus.decim_i = 8'd1;
            bus.data_in_req_i = 1'b1;
            bus.data_in_i     = 16'h0010 + 16'(i);
            step();
            chk("pt_valid", bus.data_out_valid_o, 1'b1);
            chk("pt_data", bus.data_out_o, 16'h0010 + 16'(i));
            exp_q.push_back(16'h0010 + 16'(i));
        end
        bus.data_in_req_i = 1'b0;
        step();
        chk_q("pt_out");

        // Backpressure into overflow
        do_clear(8'd1);
        bus.data_out_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.data_in_req_i = 1'b1;
            bus.data_in_i     = 16'h00A0 + 16'(i);
            step();
            chk("bp_fill", bus.fill_o, (i < 4) ? 3'(i + 1) : 3'd4);
            chk("bp_ovf", bus.overflow_o, (i >= 4) ? 1'b1 : 1'b0);
        end
        bus.data_in_req_i = 1'b0;
        chk("bp_head", bus.data_out_o, 16'h00A0);
        bus.data_out_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) step();
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h00A0 + 16'(i));
        chk_q("bp_out");
        chk("bp_drain_fill", bus.fill_o, 3'd0);
        chk("bp_sticky", bus.overflow_o, 1'b1);

        // Full FIFO with simultaneous push and pop
        bus.data_out_ready_i = 1'b0;
        do_clear(8'd1);
        chk("clr_ovf", bus.overflow_o, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bus.data_in_req_i = 1'b1;
            bus.data_in_i     = 16'h00B0 + 16'(i);
            step();
        end
        bus.data_in_req_i = 1'b0;
        chk("fu_fill", bus.fill_o, 3'd4);
        step();
        chk("fu_stable", bus.data_out_o, 16'h00B0);
        bus.data_out_ready_i = 1'b1;
        for (int i = 4; i < 8; i++) begin
            bus.data_in_req_i = 1'b1;
            bus.data_in_i     = 16'h00B0 + 16'(i);
            step();
            chk("fu_pp_fill", bus.fill_o, 3'd4);
            chk("fu_pp_ovf", bus.overflow_o, 1'b0);
        end
        bus.data_in_req_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        for (int i = 0; i < 8; i++) exp_q.push_back(16'h00B0 + 16'(i));
        chk_q("fu_out");

        // Factor 4 changed to 2 mid-period
        do_clear(8'd4);
        for (int i = 0; i < 9; i++) begin
            if (i == 2) bus.decim_i = 8'd2;
            bus.data_in_req_i = 1'b1;
            bus.data_in_i     = 16'h0040 + 16'(i);
            step();
        end
        bus.data_in_req_i = 1'b0;
        step();
        step();
        exp_q.push_back(16'h0040);
        exp_q.push_back(16'h0044);
        exp_q.push_back(16'h0046);
        exp_q.push_back(16'h0048);
        chk_q("mid_out");

        // Clear with a concurrent strobe
        bus.data_out_ready_i = 1'b0;
        for (int i = 9; i < 11; i++) begin
            bus.data_in_req_i = 1'b1;
            bus.data_in_i     = 16'h0040 + 16'(i);
            step();
        end
        chk("cl_pre_fill", bus.fill_o, 3'd1);
        bus.clear_i       = 1'b1;
        bus.data_in_req_i = 1'b1;
        bus.data_in_i     = 16'h00EE;
        step();
        bus.clear_i       = 1'b0;
        bus.data_in_req_i = 1'b0;
        chk("cl_fill", bus.fill_o, 3'd0);
        chk("cl_valid", bus.data_out_valid_o, 1'b0);
        chk("cl_ovf", bus.overflow_o, 1'b0);
        bus.data_out_ready_i = 1'b1;
        step();
        step();
        chk_q("cl_out");
        bus.data_in_req_i = 1'b1;
        bus.data_in_i     = 16'h0055;
        step();
        bus.data_in_req_i = 1'b0;
        chk("cl_first_valid", bus.data_out_valid_o, 1'b1);
        chk("cl_first_data", bus.data_out_o, 16'h0055);
        step();
        got.delete();

        // Asynchronous reset with data queued
        bus.data_out_ready_i = 1'b0;
        do_clear(8'd1);
        for (int i = 0; i < 2; i++) begin
            bus.data_in_req_i = 1'b1;
            bus.data_in_i     = 16'h0061 + 16'(i);
            step();
        end
        bus.data_in_req_i = 1'b0;
        chk("ar_pre_fill", bus.fill_o, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_fill", bus.fill_o, 3'd0);
        chk("ar_valid", bus.data_out_valid_o, 1'b0);
        chk("ar_data", bus.data_out_o, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("ar_idle", bus.data_out_valid_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/filter_decimator.md
Name: filter_decimator

Overview:
Output stage placed directly downstream of the FIR filter. It consumes the filter's output sample stream, which uses a request-only strobe and has no backpressure. It keeps every N-th sample, where N is a runtime decimation factor, and buffers the kept samples in a small FIFO. It then presents them to the consumer over a valid/ready handshake and reports overflow when the consumer stalls too long.

Parameters:
DataWidth, 16, sample width in bits (signed two's complement; passed through unmodified)
DecimWidth, 8, width of decimation factor input
Depth, 4, FIFO depth in samples; power of two, >= 2

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
clear_i  input  1  synchronous flush: FIFO, phase counter, overflow flag
decim_i  input  DecimWidth  decimation factor N; 0 treated as 1
data_in_req_i  input  1  input sample strobe; one sample per cycle when high
data_in_i  input  DataWidth  input sample, valid when data_in_req_i=1
data_out_valid_o  output  1  FIFO head valid
data_out_ready_i  input  1  consumer accepts head when valid&ready
data_out_o  output  DataWidth  FIFO head sample
fill_o  output  $clog2(Depth)+1  current FIFO occupancy
overflow_o  output  1  sticky: a kept sample was dropped

Behaviour:
- Reset is asynchronous (rst_ni=0). Values while in reset:
  - phase counter = 0
  - latched factor = 1
  - FIFO empty
  - data_out_valid_o = 0, data_out_o = 0, fill_o = 0, overflow_o = 0
- Phase counter:
  - Increments on each cycle with data_in_req_i=1.
  - The sample is kept when phase = 0.
  - phase wraps from Nlat-1 to 0.
  - The first sample after reset or clear is always kept.
- Factor latch:
  - Nlat is updated from decim_i (0 maps to 1) only when phase returns to 0, or on reset/clear.
  - Mid-period changes of decim_i take effect at the next wrap.
  - Nlat=1 means pass-through: every sample is kept.
- Push: a kept sample is written to the FIFO tail in the same cycle as the strobe.
  - The FIFO is first-word-fall-through.
  - data_out_valid_o rises the cycle after the push (latency 1 cycle from strobe to valid with an empty FIFO).
- Pop: occurs on data_out_valid_o & data_out_ready_i. The head advances next cycle.
  - data_out_o is stable while valid=1 and ready=0.
- Full FIFO with push and no pop in the same cycle:
  - The sample is dropped and the FIFO contents are unchanged.
  - overflow_o is set next cycle and stays high until clear_i or reset.
  - The phase counter still advances.
- Full FIFO with push and pop in the same cycle: both happen, no drop, fill unchanged.
- Empty FIFO with push in the same cycle:
  - The pop is not possible because valid=0; no bypass.
  - The sample appears next cycle.
- fill_o equals the number of stored samples. It is computed as push minus pop, registered, and ranges 0..Depth.
- Pointers: read/write pointers are $clog2(Depth) bits and wrap modulo Depth. Full/empty are derived from the occupancy count.
- clear_i:
  - Takes priority over push and pop in the same cycle.
  - Next cycle: FIFO empty, phase=0, overflow=0, Nlat=decim_i (0→1).
  - A data_in_req_i in the clear cycle is discarded.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. The FIFO contents are lost.
- No arithmetic is applied to sample data; bits pass through exactly.

Test Plan:
- Reset/idle: hold rst_ni=0 with data_in_req_i toggling → valid=0, fill_o=0, overflow_o=0. Release reset → still idle until the first strobe.
- Decimate by 3: decim_i=3, ready=1, strobes every cycle with data 0,1,2,...,11 → output 0,3,6,9. Each value is valid one cycle after its strobe; overflow_o=0.
- Pass-through and zero factor: decim_i=0, then decim_i=1, with 8 consecutive samples 0x0010..0x0017 and ready=1 → all 8 output in order with 1-cycle latency.
- Backpressure and overflow: Depth=4, decim_i=1, ready=0, 6 strobes with data 0xA0..0xA5 → fill_o=4, overflow_o=1. Then ready=1 → output A0,A1,A2,A3 only.
- Full with simultaneous push/pop: fill=4, ready=1 while strobing one sample per cycle → fill_o stays 4, overflow_o stays 0, order preserved.
- Mid-period factor change and clear: decim_i=4, after 2 strobes set decim_i=2 → next kept sample is at strobe index 4, then 6, 8. Assert clear_i with a concurrent strobe → fill_o=0, overflow_o=0, and the strobe in the clear cycle is not output.
